// File: rtl/signed_add_pkg.sv
// Shared definitions for the signed add scheduler.
//   W_DEF    : default operand/result width
//   sum_t    : signed value at the default width
//   req_id_e : requester identity used by the round-robin pointer
package signed_add_pkg;

   localparam int W_DEF = 4;

   typedef logic signed [W_DEF-1:0] sum_t;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

endpackage

// File: rtl/signed_add_ovf_core.sv
// Combinational signed adder with overflow detection and a clamp value.
//   i_a, i_b  : signed operands (W bits)
//   o_raw     : a + b modulo 2^W
//   o_ovf     : signed overflow of the addition
//   o_clamped : saturation limit matching the sign of the operands
module signed_add_ovf_core
   import signed_add_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_raw,
   output logic                o_ovf,
   output logic signed [W-1:0] o_clamped
);

   // Most negative value for a negative overflow, most positive otherwise.
   function automatic logic signed [W-1:0] sat_limit(input logic neg);
      return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   endfunction

   logic signed [W-1:0] w_raw;

   assign w_raw     = i_a + i_b;
   // Overflow only when both operands share a sign and the result flips it.
   assign o_ovf     = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
   assign o_raw     = w_raw;
   // When overflow occurs both operands share a sign, so a's sign decides.
   assign o_clamped = sat_limit(i_a[W-1]);

endmodule

// File: rtl/signed_add_scheduler.sv
// Two-requester round-robin front end for one shared signed adder.
//   clk, rst            : clock, asynchronous active-high reset
//   reqN_vld/rdy/a/b    : per-requester valid/ready operand handshake (N=0,1)
//   res_vld/res_rdy     : registered result handshake towards the consumer
//   res_sum/ovf/id      : sum (wrapped or clamped), overflow flag, issuer
//   ovf_cnt             : saturating count of overflowed results consumed
module signed_add_scheduler
   import signed_add_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter bit SATURATE = 1'b0,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_vld,
   output logic                req0_rdy,
   input  logic signed [W-1:0] req0_a,
   input  logic signed [W-1:0] req0_b,
   input  logic                req1_vld,
   output logic                req1_rdy,
   input  logic signed [W-1:0] req1_a,
   input  logic signed [W-1:0] req1_b,
   output logic                res_vld,
   input  logic                res_rdy,
   output logic signed [W-1:0] res_sum,
   output logic                res_ovf,
   output logic                res_id,
   output logic [CNT_W-1:0]    ovf_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   req_id_e             r_last;
   logic                r_res_vld;
   logic signed [W-1:0] r_res_sum;
   logic                r_res_ovf;
   logic                r_res_id;
   logic [CNT_W-1:0]    r_ovf_cnt;

   logic                w_slot_free;
   logic                w_gnt1;
   logic                w_xfer;
   logic signed [W-1:0] w_op_a;
   logic signed [W-1:0] w_op_b;
   logic signed [W-1:0] w_raw;
   logic signed [W-1:0] w_clamped;
   logic signed [W-1:0] w_sum;
   logic                w_ovf;

   // The output slot can take a new result if empty or being drained now.
   assign w_slot_free = !r_res_vld || res_rdy;

   // Round-robin: under contention the requester not granted last wins.
   always_comb begin
      w_gnt1 = 1'b0;
      if (req0_vld && req1_vld) begin
         w_gnt1 = (r_last == REQ0);
      end else begin
         w_gnt1 = req1_vld;
      end
   end

   assign req0_rdy = !rst && w_slot_free && req0_vld && !w_gnt1;
   assign req1_rdy = !rst && w_slot_free && req1_vld &&  w_gnt1;
   assign w_xfer   = req0_rdy || req1_rdy;

   assign w_op_a = w_gnt1 ? req1_a : req0_a;
   assign w_op_b = w_gnt1 ? req1_b : req0_b;

   signed_add_ovf_core #(.W(W)) u_core (
      .i_a       (w_op_a),
      .i_b       (w_op_b),
      .o_raw     (w_raw),
      .o_ovf     (w_ovf),
      .o_clamped (w_clamped)
   );

   assign w_sum = (SATURATE && w_ovf) ? w_clamped : w_raw;

   // Round-robin pointer; starts at REQ1 so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= REQ1;
      end else if (w_xfer) begin
         r_last <= w_gnt1 ? REQ1 : REQ0;
      end
   end

   // Output register stage: load on transfer, clear valid on a bare drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_vld <= 1'b0;
         r_res_sum <= '0;
         r_res_ovf <= 1'b0;
         r_res_id  <= 1'b0;
      end else if (w_xfer) begin
         r_res_vld <= 1'b1;
         r_res_sum <= w_sum;
         r_res_ovf <= w_ovf;
         r_res_id  <= w_gnt1;
      end else if (res_rdy) begin
         r_res_vld <= 1'b0;
      end
   end

   // Counts overflowed results as they are consumed, holding at full scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf_cnt <= '0;
      end else if (r_res_vld && res_rdy && r_res_ovf && (r_ovf_cnt != CNT_MAX)) begin
         r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
   end

   assign res_vld = r_res_vld;
   assign res_sum = r_res_sum;
   assign res_ovf = r_res_ovf;
   assign res_id  = r_res_id;
   assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_signed_add_scheduler.sv
module tb_signed_add_scheduler;

   typedef struct packed {
      logic [3:0] sum;
      logic       ovf;
      logic       id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Instance 0: wrapping, 8-bit counter
   logic       a_r0v = 0, a_r1v = 0, a_rrdy = 0;
   logic [3:0] a_r0a = 0, a_r0b = 0, a_r1a = 0, a_r1b = 0;
   logic       a_r0rdy, a_r1rdy, a_vld, a_ovf, a_id;
   logic [3:0] a_sum;
   logic [7:0] a_cnt;

   // Instance 1: saturating, 2-bit counter
   logic       b_r0v = 0, b_r1v = 0, b_rrdy = 0;
   logic [3:0] b_r0a = 0, b_r0b = 0, b_r1a = 0, b_r1b = 0;
   logic       b_r0rdy, b_r1rdy, b_vld, b_ovf, b_id;
   logic [3:0] b_sum;
   logic [1:0] b_cnt;

   int n_vec = 0;
   int n_err = 0;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   signed_add_scheduler #(.W(4), .SATURATE(1'b0), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst),
      .req0_vld(a_r0v), .req0_rdy(a_r0rdy), .req0_a(a_r0a), .req0_b(a_r0b),
      .req1_vld(a_r1v), .req1_rdy(a_r1rdy), .req1_a(a_r1a), .req1_b(a_r1b),
      .res_vld(a_vld), .res_rdy(a_rrdy), .res_sum(a_sum), .res_ovf(a_ovf),
      .res_id(a_id), .ovf_cnt(a_cnt)
   );

   signed_add_scheduler #(.W(4), .SATURATE(1'b1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst),
      .req0_vld(b_r0v), .req0_rdy(b_r0rdy), .req0_a(b_r0a), .req0_b(b_r0b),
      .req1_vld(b_r1v), .req1_rdy(b_r1rdy), .req1_a(b_r1a), .req1_b(b_r1b),
      .res_vld(b_vld), .res_rdy(b_rrdy), .res_sum(b_sum), .res_ovf(b_ovf),
      .res_id(b_id), .ovf_cnt(b_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference W=4 signed add: returns {ovf, sum}.
   function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input bit sat);
      logic [3:0] raw;
      logic       ovf;
      raw = a + b;
      ovf = (a[3] == b[3]) && (raw[3] != a[3]);
      if (sat && ovf) return {1'b1, (a[3] ? 4'h8 : 4'h7)};
      return {ovf, raw};
   endfunction

   function automatic exp_t mk_exp(input logic [3:0] a, input logic [3:0] b, input bit sat, input logic id);
      logic [4:0] m;
      exp_t e;
      m = model(a, b, sat);
      e.sum = m[3:0];
      e.ovf = m[4];
      e.id  = id;
      return e;
   endfunction

   // Scoreboards: drains are compared before the same cycle's transfer is queued.
   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (a_vld && a_rrdy) begin
            if (q0.size() == 0) check_val("sb0_unexpected", 1, 0);
            else begin
               exp_t e;
               e = q0.pop_front();
               check_val("sb0_sum", {28'd0, a_sum}, {28'd0, e.sum});
               check_val("sb0_ovf", {31'd0, a_ovf}, {31'd0, e.ovf});
               check_val("sb0_id",  {31'd0, a_id},  {31'd0, e.id});
            end
         end
         if (a_r0v && a_r0rdy) q0.push_back(mk_exp(a_r0a, a_r0b, 1'b0, 1'b0));
         if (a_r1v && a_r1rdy) q0.push_back(mk_exp(a_r1a, a_r1b, 1'b0, 1'b1));

         if (b_vld && b_rrdy) begin
            if (q1.size() == 0) check_val("sb1_unexpected", 1, 0);
            else begin
               exp_t e;
               e = q1.pop_front();
               check_val("sb1_sum", {28'd0, b_sum}, {28'd0, e.sum});
               check_val("sb1_ovf", {31'd0, b_ovf}, {31'd0, e.ovf});
            end
         end
         if (b_r0v && b_r0rdy) q1.push_back(mk_exp(b_r0a, b_r0b, 1'b1, 1'b0));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [3:0] sat_a [4] = '{4'd7, 4'd9,  4'd12, 4'd4};
   logic [3:0] sat_b [4] = '{4'd4, 4'd12, 4'd12, 4'd12};
   logic [3:0] sat_s [4] = '{4'd7, 4'd8,  4'd8,  4'd0};
   logic       sat_o [4] = '{1'b1, 1'b1,  1'b0,  1'b0};
   logic [1:0] cnt_e [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      // Reset state, with a pending request that must not be accepted
      a_r0v = 1; a_rrdy = 1;
      #3;
      check_val("rst_rdy0", {31'd0, a_r0rdy}, 0);
      check_val("rst_vld",  {31'd0, a_vld}, 0);
      check_val("rst_cnt",  {24'd0, a_cnt}, 0);
      a_r0v = 0;
      step(); step();
      rst = 0;

      // Single request 3 + -5
      a_r0a = 4'd3; a_r0b = 4'd11; a_r0v = 1; a_rrdy = 1;
      #1;
      check_val("single_rdy0", {31'd0, a_r0rdy}, 1);
      step();
      check_val("single_vld", {31'd0, a_vld}, 1);
      check_val("single_sum", {28'd0, a_sum}, 32'hE);
      check_val("single_ovf", {31'd0, a_ovf}, 0);
      check_val("single_id",  {31'd0, a_id}, 0);

      // One overflowing result so the counter is non-zero before reset
      a_r0a = 4'd7; a_r0b = 4'd1;
      step();
      check_val("ovf_sum", {28'd0, a_sum}, 32'h8);
      check_val("ovf_flag", {31'd0, a_ovf}, 1);
      a_r0v = 0;
      step();
      check_val("drain_vld", {31'd0, a_vld}, 0);
      check_val("drain_cnt", {24'd0, a_cnt}, 1);

      // Mid-stream reset with a held result and both requesters pending
      a_r0a = 4'd2; a_r0b = 4'd2; a_r0v = 1;
      a_r1a = 4'd1; a_r1b = 4'd1; a_r1v = 1; a_rrdy = 0;
      step();
      check_val("hold_vld", {31'd0, a_vld}, 1);
      rst = 1;
      #1;
      check_val("midrst_vld", {31'd0, a_vld}, 0);
      check_val("midrst_sum", {28'd0, a_sum}, 0);
      check_val("midrst_ovf", {31'd0, a_ovf}, 0);
      check_val("midrst_id",  {31'd0, a_id}, 0);
      check_val("midrst_cnt", {24'd0, a_cnt}, 0);
      check_val("midrst_rdy0", {31'd0, a_r0rdy}, 0);
      check_val("midrst_rdy1", {31'd0, a_r1rdy}, 0);
      step();
      rst = 0;

      // Continuous contention: 4+7 vs -4+-7
      a_r0a = 4'd4; a_r0b = 4'd7; a_r1a = 4'd12; a_r1b = 4'd9; a_rrdy = 1;
      #1;
      check_val("cont_rdy0", {31'd0, a_r0rdy}, 1);
      check_val("cont_rdy1", {31'd0, a_r1rdy}, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("cont_id",  {31'd0, a_id}, (i % 2));
         check_val("cont_sum", {28'd0, a_sum}, (i % 2 == 0) ? 32'hB : 32'h5);
         check_val("cont_ovf", {31'd0, a_ovf}, 1);
         check_val("cont_cnt", {24'd0, a_cnt}, i);
      end
      a_r0v = 0; a_r1v = 0;
      step();
      check_val("cont_cnt_end", {24'd0, a_cnt}, 4);

      // Backpressure
      a_r0a = 4'd1; a_r0b = 4'd2; a_r0v = 1; a_rrdy = 0;
      step();
      a_r0a = 4'd2; a_r0b = 4'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("bp_rdy0", {31'd0, a_r0rdy}, 0);
         check_val("bp_vld",  {31'd0, a_vld}, 1);
         check_val("bp_sum",  {28'd0, a_sum}, 3);
         if (i < 2) step();
      end
      a_rrdy = 1;
      #1;
      check_val("bp_release_rdy0", {31'd0, a_r0rdy}, 1);
      step();
      check_val("bp_new_vld", {31'd0, a_vld}, 1);
      check_val("bp_new_sum", {28'd0, a_sum}, 4);
      a_r0v = 0;
      step();

      // Saturating instance vectors
      b_rrdy = 1;
      for (int i = 0; i < 4; i++) begin
         b_r0a = sat_a[i]; b_r0b = sat_b[i]; b_r0v = 1;
         step();
         check_val("sat_sum", {28'd0, b_sum}, {28'd0, sat_s[i]});
         check_val("sat_ovf", {31'd0, b_ovf}, {31'd0, sat_o[i]});
      end
      b_r0v = 0;
      step();
      check_val("sat_cnt", {30'd0, b_cnt}, 2);

      // Counter saturation on a 2-bit counter
      rst = 1;
      step();
      rst = 0;
      b_r0a = 4'd7; b_r0b = 4'd4; b_r0v = 1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 5) b_r0v = 0;
         if (i >= 2) check_val("cnt_sat", {30'd0, b_cnt}, {30'd0, cnt_e[i-2]});
      end
      step();

      check_val("sb0_left", q0.size(), 0);
      check_val("sb1_left", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
